// File: rtl/addr_xlate_pipe_pkg.sv
// ============================================================================
// Module   : xlate_pkg
// Purpose  : Shared types and helpers for the MIPS fixed-segment address
//            translator: bus request type, segment decode, translation and
//            alignment checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package xlate_pkg;

    // Access size of a data-bus request
    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    // Data-bus request; valid qualifies the remaining fields
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    // Fixed MIPS segments selected by vaddr[31:29]
    typedef enum logic [1:0] {
        USEG   = 2'd0,
        KSEG0  = 2'd1,
        KSEG1  = 2'd2,
        KSEG23 = 2'd3
    } seg_t;

    localparam logic [31:0] KSEG_MASK = 32'h1fff_ffff;

    // Translated request plus its cacheability decision
    typedef struct packed {
        dbus_req_t req;
        logic      uncached;
    } xlate_resp_t;

    // Result of the segment mapping
    typedef struct packed {
        logic [31:0] paddr;
        logic        uncached;
    } xlate_map_t;

    function automatic seg_t seg_of(input logic [31:0] vaddr);
        seg_t s;
        case (vaddr[31:29])
            3'b100:         s = KSEG0;
            3'b101:         s = KSEG1;
            3'b110, 3'b111: s = KSEG23;
            default:        s = USEG;
        endcase
        return s;
    endfunction

    // kseg0/kseg1 strip the top three bits; useg and kseg2/3 pass through
    // unchanged (no TLB in this core).
    function automatic xlate_map_t xlate(input logic [31:0] vaddr,
                                         input logic        k0_uc);
        xlate_map_t m;
        m.paddr    = vaddr;
        m.uncached = 1'b0;
        case (seg_of(vaddr))
            KSEG0: begin
                m.paddr    = vaddr & KSEG_MASK;
                m.uncached = k0_uc;
            end
            KSEG1: begin
                m.paddr    = vaddr & KSEG_MASK;
                m.uncached = 1'b1;
            end
            default: ;
        endcase
        return m;
    endfunction

    function automatic logic misaligned(input logic [31:0] addr,
                                        input msize_t      size);
        logic r;
        case (size)
            MSIZE2:  r = addr[0];
            MSIZE4:  r = |addr[1:0];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/addr_xlate_pipe_if.sv
// ============================================================================
// Module   : addr_xlate_pipe_if
// Purpose  : Per-channel request/response/fault bundle of the address
//            translator. master = requester side, slave = translator side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface addr_xlate_pipe_if #(
    parameter int NUM_CH = 2
);
    import xlate_pkg::*;

    dbus_req_t          in_req      [NUM_CH];
    logic [NUM_CH-1:0]  in_ready;
    dbus_req_t          out_req     [NUM_CH];
    logic [NUM_CH-1:0]  out_uncached;
    logic [NUM_CH-1:0]  out_ready;
    logic [NUM_CH-1:0]  fault_valid;
    logic [31:0]        fault_addr  [NUM_CH];
    logic [NUM_CH-1:0]  fault_store;

    modport master (
        output in_req,
        output out_ready,
        input  in_ready,
        input  out_req,
        input  out_uncached,
        input  fault_valid,
        input  fault_addr,
        input  fault_store
    );

    modport slave (
        input  in_req,
        input  out_ready,
        output in_ready,
        output out_req,
        output out_uncached,
        output fault_valid,
        output fault_addr,
        output fault_store
    );

endinterface

`default_nettype wire

// File: rtl/addr_xlate_pipe_skid.sv
// ============================================================================
// Module   : xlate_skid
// Purpose  : Two-entry valid/ready buffer (main + skid register) for one
//            translator channel. Strict FIFO order, 1 entry/cycle when the
//            consumer is ready, push_ready is a pure register output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xlate_skid
    import xlate_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        resetn,
    input  wire logic        push_valid,
    input  wire xlate_resp_t push_data,
    output logic             push_ready,
    output logic             pop_valid,
    output xlate_resp_t      pop_data,
    input  wire logic        pop_ready
);

    xlate_resp_t r_main;
    logic        r_main_valid;
    xlate_resp_t r_skid;
    logic        r_skid_valid;

    // Main register refills from the skid entry first so ordering is kept;
    // a push while main is stalled parks in the skid entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_main       <= '0;
            r_main_valid <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || pop_ready) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (push_valid) begin
                r_main       <= push_data;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (push_valid) begin
            r_skid       <= push_data;
            r_skid_valid <= 1'b1;
        end
    end

    assign push_ready = !r_skid_valid;
    assign pop_valid  = r_main_valid;
    assign pop_data   = r_main;

endmodule

`default_nettype wire

// File: rtl/addr_xlate_pipe.sv
// ============================================================================
// Module   : addr_xlate_pipe
// Purpose  : Registered multi-channel MIPS virtual-to-physical translator.
//            Per channel: fixed-segment mapping, cacheability (segment and
//            MMIO window), alignment/privilege faults, one-cycle latency,
//            full-throughput skid buffering.
// Options  : ADDR_XLATE_PERF_EN adds per-channel perf counters
//            (perf_acc / perf_unc / perf_flt).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module addr_xlate_pipe
    import xlate_pkg::*;
#(
    parameter int          NUM_CH  = 2,
    parameter logic [31:0] MMIO_LO = 32'h1000_0000,
    parameter logic [31:0] MMIO_HI = 32'h1fff_ffff
) (
    input  wire logic               clk,
    input  wire logic               resetn,
    input  wire logic               user_mode,
    input  wire logic               k0_uncached,
    addr_xlate_pipe_if.slave        bus
`ifdef ADDR_XLATE_PERF_EN
    ,
    output logic [NUM_CH-1:0][31:0] perf_acc,
    output logic [NUM_CH-1:0][31:0] perf_unc,
    output logic [NUM_CH-1:0][31:0] perf_flt
`endif
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        xlate_map_t  w_map;
        logic        w_mmio;
        logic        w_fault;
        logic        w_in_ready;
        logic        w_accept;
        logic        w_push;
        xlate_resp_t w_push_data;
        logic        w_pop_valid;
        xlate_resp_t w_pop_data;
        dbus_req_t   w_out;
        logic        r_fault_valid;
        logic [31:0] r_fault_addr;
        logic        r_fault_store;

        assign w_map    = xlate(bus.in_req[g].addr, k0_uncached);
        assign w_mmio   = (w_map.paddr >= MMIO_LO) && (w_map.paddr <= MMIO_HI);
        assign w_fault  = misaligned(bus.in_req[g].addr, bus.in_req[g].size) ||
                          (user_mode && bus.in_req[g].addr[31]);
        assign w_accept = bus.in_req[g].valid && w_in_ready;
        // A faulting request is consumed but never enters the buffer
        assign w_push   = w_accept && !w_fault;

        // Build the buffered entry: only the address is rewritten
        always_comb begin
            w_push_data          = '0;
            w_push_data.req      = bus.in_req[g];
            w_push_data.req.addr = w_map.paddr;
            w_push_data.uncached = w_map.uncached | w_mmio;
        end

        xlate_skid u_skid (
            .clk        (clk),
            .resetn     (resetn),
            .push_valid (w_push),
            .push_data  (w_push_data),
            .push_ready (w_in_ready),
            .pop_valid  (w_pop_valid),
            .pop_data   (w_pop_data),
            .pop_ready  (bus.out_ready[g])
        );

        // Present the head entry with valid taken from buffer occupancy
        always_comb begin
            w_out       = w_pop_data.req;
            w_out.valid = w_pop_valid;
        end

        assign bus.in_ready[g]     = w_in_ready;
        assign bus.out_req[g]      = w_out;
        assign bus.out_uncached[g] = w_pop_valid & w_pop_data.uncached;

        // Fault report: one-cycle pulse after the faulting accept; the
        // address/store fields keep the last fault for software inspection.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_fault_valid <= 1'b0;
                r_fault_addr  <= '0;
                r_fault_store <= 1'b0;
            end else begin
                r_fault_valid <= w_accept && w_fault;
                if (w_accept && w_fault) begin
                    r_fault_addr  <= bus.in_req[g].addr;
                    r_fault_store <= |bus.in_req[g].strobe;
                end
            end
        end

        assign bus.fault_valid[g] = r_fault_valid;
        assign bus.fault_addr[g]  = r_fault_addr;
        assign bus.fault_store[g] = r_fault_store;

`ifdef ADDR_XLATE_PERF_EN
        logic [31:0] r_perf_acc;
        logic [31:0] r_perf_unc;
        logic [31:0] r_perf_flt;

        // Free-running event counters, wrap naturally at 2^32
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_perf_acc <= '0;
                r_perf_unc <= '0;
                r_perf_flt <= '0;
            end else begin
                if (w_accept)
                    r_perf_acc <= r_perf_acc + 32'd1;
                if (w_pop_valid && bus.out_ready[g] && w_pop_data.uncached)
                    r_perf_unc <= r_perf_unc + 32'd1;
                if (w_accept && w_fault)
                    r_perf_flt <= r_perf_flt + 32'd1;
            end
        end

        assign perf_acc[g] = r_perf_acc;
        assign perf_unc[g] = r_perf_unc;
        assign perf_flt[g] = r_perf_flt;
`endif
    end : g_ch

endmodule

`default_nettype wire

// File: tb/tb_addr_xlate_pipe.sv
// ============================================================================
// Module   : tb_addr_xlate_pipe
// Purpose  : Scoreboard bench for addr_xlate_pipe: directed scenarios plus
//            randomized traffic against a segment-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_addr_xlate_pipe;
    import xlate_pkg::*;

    localparam int          NCH = 2;
    localparam logic [31:0] LO  = 32'h1000_0000;
    localparam logic [31:0] HI  = 32'h1fff_ffff;

    typedef struct {
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic        uc;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        store;
        int          cyc;
    } fexp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic user_mode = 1'b0;
    logic k0_uncached = 1'b0;

    addr_xlate_pipe_if #(.NUM_CH(NCH)) bus ();

`ifdef ADDR_XLATE_PERF_EN
    logic [NCH-1:0][31:0] perf_acc;
    logic [NCH-1:0][31:0] perf_unc;
    logic [NCH-1:0][31:0] perf_flt;
`endif

    addr_xlate_pipe #(
        .NUM_CH  (NCH),
        .MMIO_LO (LO),
        .MMIO_HI (HI)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .user_mode   (user_mode),
        .k0_uncached (k0_uncached),
        .bus         (bus)
`ifdef ADDR_XLATE_PERF_EN
        ,
        .perf_acc    (perf_acc),
        .perf_unc    (perf_unc),
        .perf_flt    (perf_flt)
`endif
    );

    always #5 clk = ~clk;

    exp_t      oq [NCH][$];
    fexp_t     fq [NCH][$];
    int        cyc = 0;
    int        n_chk = 0;
    int        n_fail = 0;
    bit        strict_lat [NCH];
    bit        acc_flag [NCH];
    int        m_acc [NCH];
    int        m_unc [NCH];
    int        m_flt [NCH];
    dbus_req_t st_req [NCH];
    logic      st_ordy [NCH];
    logic      st_um = 1'b0;
    logic      st_k0 = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s ch%0d @cyc %0d: got %h expected %h", name, c, cyc, act, exp);
        end
    endtask

    // Reference model: segment arithmetic straight from the address map
    task automatic model_accept(input int c, input dbus_req_t r, input logic um,
                                input logic k0);
        logic [31:0] pa;
        logic        uc;
        logic        flt;
        int unsigned seg;
        exp_t        e;
        fexp_t       f;
        seg = r.addr / 32'h2000_0000;
        if (seg == 4) begin
            pa = r.addr - 32'h8000_0000;
            uc = k0;
        end else if (seg == 5) begin
            pa = r.addr - 32'ha000_0000;
            uc = 1'b1;
        end else begin
            pa = r.addr;
            uc = 1'b0;
        end
        if (pa >= LO && pa <= HI) uc = 1'b1;
        flt = (r.size == MSIZE2 && (r.addr % 2) != 0) ||
              (r.size == MSIZE4 && (r.addr % 4) != 0) ||
              (um && r.addr >= 32'h8000_0000);
        m_acc[c]++;
        if (flt) begin
            f.addr  = r.addr;
            f.store = (r.strobe != 4'd0);
            f.cyc   = cyc;
            fq[c].push_back(f);
            m_flt[c]++;
        end else begin
            e.addr   = pa;
            e.size   = r.size;
            e.strobe = r.strobe;
            e.data   = r.data;
            e.uc     = uc;
            e.cyc    = cyc;
            oq[c].push_back(e);
        end
    endtask

    // Apply staged stimulus (called 2 time units after a rising edge),
    // record accepts, then advance one cycle.
    task automatic tick();
        user_mode   = st_um;
        k0_uncached = st_k0;
        for (int c = 0; c < NCH; c++) begin
            bus.in_req[c]    = st_req[c];
            bus.out_ready[c] = st_ordy[c];
        end
        for (int c = 0; c < NCH; c++) begin
            chk("in_ready", c, {31'd0, bus.in_ready[c]}, {31'd0, oq[c].size() < 2});
            acc_flag[c] = st_req[c].valid && bus.in_ready[c];
            if (acc_flag[c]) model_accept(c, st_req[c], st_um, st_k0);
        end
        @(posedge clk);
        #2;
    endtask

    function automatic dbus_req_t mk(input logic [31:0] a, input msize_t s,
                                     input logic [3:0] sb);
        dbus_req_t r;
        r.valid  = 1'b1;
        r.addr   = a;
        r.size   = s;
        r.strobe = sb;
        r.data   = $urandom;
        return r;
    endfunction

    function automatic dbus_req_t rnd_req();
        dbus_req_t   r;
        logic [31:0] low;
        logic [2:0]  seg;
        seg = 3'($urandom % 8);
        low = $urandom;
        if ($urandom % 3 == 0) low[28] = 1'b1; // land in the MMIO window
        r.addr = {seg, low[28:0]};
        case ($urandom % 3)
            0:       r.size = MSIZE1;
            1:       r.size = MSIZE2;
            default: r.size = MSIZE4;
        endcase
        if ($urandom % 4 != 0) r.addr[1:0] = 2'b00;
        r.strobe = 4'($urandom);
        r.data   = $urandom;
        r.valid  = ($urandom % 4 != 0);
        return r;
    endfunction

    task automatic send(input int c, input logic [31:0] a, input msize_t s,
                        input logic [3:0] sb);
        int n;
        n = 0;
        st_req[c] = mk(a, s, sb);
        do begin
            tick();
            n++;
        end while (!acc_flag[c] && n < 20);
        chk("send_accept", c, {31'd0, acc_flag[c]}, 32'd1);
        st_req[c].valid = 1'b0;
    endtask

    // Monitor: late in each cycle, compare presented outputs with the
    // scoreboard; pop on the handshake that completes at the next edge.
    always @(posedge clk) begin
        exp_t  e;
        fexp_t f;
        logic  fexp;
        #7;
        if (resetn) begin
            for (int c = 0; c < NCH; c++) begin
                fexp = (fq[c].size() > 0) && (fq[c][0].cyc + 1 == cyc);
                chk("fault_valid", c, {31'd0, bus.fault_valid[c]}, {31'd0, fexp});
                if (fexp) begin
                    f = fq[c].pop_front();
                    chk("fault_addr", c, bus.fault_addr[c], f.addr);
                    chk("fault_store", c, {31'd0, bus.fault_store[c]}, {31'd0, f.store});
                end
                if (bus.out_req[c].valid) begin
                    if (oq[c].size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL spurious_out ch%0d @cyc %0d: got addr %h expected no request",
                                 c, cyc, bus.out_req[c].addr);
                    end else begin
                        e = oq[c][0];
                        chk("out_addr", c, bus.out_req[c].addr, e.addr);
                        chk("out_size", c, {30'd0, bus.out_req[c].size}, {30'd0, e.size});
                        chk("out_strobe", c, {28'd0, bus.out_req[c].strobe}, {28'd0, e.strobe});
                        chk("out_data", c, bus.out_req[c].data, e.data);
                        chk("out_uncached", c, {31'd0, bus.out_uncached[c]}, {31'd0, e.uc});
                        if (strict_lat[c] && bus.out_ready[c])
                            chk("latency", c, cyc, e.cyc + 1);
                        if (bus.out_ready[c]) begin
                            if (e.uc) m_unc[c]++;
                            void'(oq[c].pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic reset_checks();
        for (int c = 0; c < NCH; c++) begin
            chk("rst_out_valid", c, {31'd0, bus.out_req[c].valid}, 32'd0);
            chk("rst_out_req", c, {31'd0, (bus.out_req[c] != '0)}, 32'd0);
            chk("rst_out_uncached", c, {31'd0, bus.out_uncached[c]}, 32'd0);
            chk("rst_in_ready", c, {31'd0, bus.in_ready[c]}, 32'd1);
            chk("rst_fault_valid", c, {31'd0, bus.fault_valid[c]}, 32'd0);
`ifdef ADDR_XLATE_PERF_EN
            chk("rst_perf_acc", c, perf_acc[c], 32'd0);
            chk("rst_perf_unc", c, perf_unc[c], 32'd0);
            chk("rst_perf_flt", c, perf_flt[c], 32'd0);
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int cnt;
        for (int c = 0; c < NCH; c++) begin
            st_req[c]        = '0;
            st_ordy[c]       = 1'b1;
            bus.in_req[c]    = '0;
            bus.out_ready[c] = 1'b1;
            strict_lat[c]    = 1'b0;
            m_acc[c] = 0;
            m_unc[c] = 0;
            m_flt[c] = 0;
        end
        repeat (2) @(posedge clk);
        #2;
        reset_checks();
        resetn = 1'b1;
        @(posedge clk);
        #2;

        // kseg0 cached, kseg1 uncached + MMIO
        send(0, 32'h8000_1234, MSIZE4, 4'hf);
        send(1, 32'hbfd0_0010, MSIZE4, 4'h0);
        st_k0 = 1'b1;
        send(0, 32'h8000_2000, MSIZE2, 4'h3);
        st_k0 = 1'b0;
        send(1, 32'h1000_0000, MSIZE1, 4'h1);
        send(1, 32'h0fff_fffc, MSIZE4, 4'h0);

        // misaligned and privilege faults
        send(0, 32'h9fc0_0002, MSIZE4, 4'h0);
        tick();
        st_um = 1'b1;
        send(0, 32'h8000_0000, MSIZE4, 4'hf);
        send(1, 32'h0040_0001, MSIZE2, 4'h3);
        st_um = 1'b0;
        repeat (2) tick();

        // stall with three back-to-back requests, then release
        st_ordy[0] = 1'b0;
        k = 0;
        for (int t = 0; t < 10; t++) begin
            if (k < 3) st_req[0] = mk(32'h0000_0100 + 32'(k * 4), MSIZE4, 4'hf);
            else st_req[0].valid = 1'b0;
            if (t == 6) st_ordy[0] = 1'b1;
            tick();
            if (acc_flag[0]) k++;
        end
        chk("stall_accepts", 0, k, 3);
        st_req[0].valid = 1'b0;
        repeat (3) tick();

        // ch0 stalled while ch1 streams at full rate
        st_ordy[0] = 1'b0;
        send(0, 32'h0000_0200, MSIZE4, 4'h0);
        strict_lat[1] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            st_req[1] = mk(32'h8000_4000 + 32'(i * 4), MSIZE4, 4'h0);
            tick();
            if (acc_flag[1]) cnt++;
        end
        st_req[1].valid = 1'b0;
        repeat (2) tick();
        strict_lat[1] = 1'b0;
        chk("stream_accepts", 1, cnt, 8);
        st_ordy[0] = 1'b1;
        repeat (3) tick();

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            for (int c = 0; c < NCH; c++) begin
                st_req[c]  = rnd_req();
                st_ordy[c] = ($urandom % 10) < 7;
            end
            st_um = ($urandom % 8 == 0);
            st_k0 = ($urandom % 2 == 1);
            tick();
        end

        // drain and check nothing is left over
        for (int c = 0; c < NCH; c++) begin
            st_req[c].valid = 1'b0;
            st_ordy[c]      = 1'b1;
        end
        st_um = 1'b0;
        k = 0;
        while ((oq[0].size() + oq[1].size() + fq[0].size() + fq[1].size()) != 0 && k < 20) begin
            tick();
            k++;
        end
        repeat (2) tick();
        for (int c = 0; c < NCH; c++) begin
            chk("drain_outq", c, oq[c].size(), 0);
            chk("drain_faultq", c, fq[c].size(), 0);
`ifdef ADDR_XLATE_PERF_EN
            chk("perf_acc", c, perf_acc[c], m_acc[c]);
            chk("perf_unc", c, perf_unc[c], m_unc[c]);
            chk("perf_flt", c, perf_flt[c], m_flt[c]);
`endif
        end

        // reset with main + skid full on ch0
        st_ordy[0] = 1'b0;
        send(0, 32'h8000_0300, MSIZE4, 4'h0);
        send(0, 32'h8000_0304, MSIZE4, 4'h0);
        tick();
        resetn = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            oq[c].delete();
            fq[c].delete();
            m_acc[c] = 0;
            m_unc[c] = 0;
            m_flt[c] = 0;
        end
        #1;
        reset_checks();
        st_ordy[0] = 1'b1;
        @(posedge clk);
        #2;
        resetn = 1'b1;
        send(0, 32'ha000_0040, MSIZE4, 4'hf);
        repeat (3) tick();
        chk("post_reset_drain", 0, oq[0].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
